// File: rtl/lsu_access_unit_pkg.sv
// Shared memory-op encoding and helpers for the load/store access unit.
package lsu_access_unit_pkg;

    localparam logic [7:0] MEM_LB  = 8'h01;
    localparam logic [7:0] MEM_LBU = 8'h02;
    localparam logic [7:0] MEM_LH  = 8'h03;
    localparam logic [7:0] MEM_LHU = 8'h04;
    localparam logic [7:0] MEM_LW  = 8'h05;
    localparam logic [7:0] MEM_LD  = 8'h06;
    localparam logic [7:0] MEM_LWL = 8'h07;
    localparam logic [7:0] MEM_LWR = 8'h08;
    localparam logic [7:0] MEM_SB  = 8'h11;
    localparam logic [7:0] MEM_SH  = 8'h12;
    localparam logic [7:0] MEM_SW  = 8'h13;
    localparam logic [7:0] MEM_SD  = 8'h14;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_EXC} lsu_state_e;

    // Access size in bytes; 0 for codes that never touch data lanes.
    function automatic int mem_bytes(input logic [7:0] op);
        case (op)
            MEM_LB, MEM_LBU, MEM_SB:          return 1;
            MEM_LH, MEM_LHU, MEM_SH:          return 2;
            MEM_LW, MEM_SW, MEM_LWL, MEM_LWR: return 4;
            MEM_LD, MEM_SD:                   return 8;
            default:                          return 0;
        endcase
    endfunction

    function automatic logic mem_is_store(input logic [7:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW) || (op == MEM_SD);
    endfunction

endpackage

// File: rtl/lsu_pend_fifo.sv
// Synchronous FIFO holding per-transaction load context in issue order.
module lsu_pend_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store access unit: alignment check, lane steering, outstanding tracking, load extension.
// LSU_UNALIGNED_EN adds LWL/LWR merge loads; without it they decode as LW.
module lsu_access_unit
    import lsu_access_unit_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int PEND_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_req,
    output logic                bus_wr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_exc_adel,
    output logic                resp_exc_ades,
    output logic [ADDR_W-1:0]   resp_badvaddr
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(PEND_DEPTH + 1);
`ifdef LSU_UNALIGNED_EN
    localparam int ENT_W = 8 + OFF_W + DATA_W;
`else
    localparam int ENT_W = 8 + OFF_W;
`endif

    lsu_state_e        state_q, state_d;
    logic              bus_req_q, bus_req_d, bus_wr_q, bus_wr_d;
    logic [BE_W-1:0]   bus_be_q, bus_be_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [ENT_W-1:0]  ent_q, ent_d;
    logic              resp_valid_q, resp_valid_d, adel_q, adel_d, ades_q, ades_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] bad_q, bad_d;

    logic [7:0]        dec_op;
    int                dec_bytes;
    logic              dec_st, dec_mis;
    logic [OFF_W-1:0]  off;
    logic [BE_W-1:0]   dec_be;
    logic [DATA_W-1:0] dec_wdata;

    logic              push, pop, accept, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    occ;
    logic [ENT_W-1:0]  fifo_dout;
    logic [7:0]        h_op;
    logic [OFF_W-1:0]  h_off;
    logic [DATA_W-1:0] sh, ld_data;

    function automatic logic [DATA_W-1:0] ext(input logic [DATA_W-1:0] v, input int bits,
                                              input logic sbit);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = (i < bits) ? v[i] : sbit;
        return r;
    endfunction

    assign off = req_addr[OFF_W-1:0];

    always_comb begin
        dec_op = req_op;
`ifndef LSU_UNALIGNED_EN
        if (req_op == MEM_LWL || req_op == MEM_LWR) dec_op = MEM_LW;
`endif
        dec_bytes = mem_bytes(dec_op);
        // Doubleword codes on a narrow bus collapse to a zero-returning load.
        if (dec_bytes > BE_W) begin
            dec_op    = MEM_LD;
            dec_bytes = 0;
        end
        dec_st  = mem_is_store(dec_op);
        dec_mis = 1'b0;
        case (dec_bytes)
            2:       dec_mis = req_addr[0];
            4:       dec_mis = |req_addr[1:0];
            8:       dec_mis = |req_addr[2:0];
            default: dec_mis = 1'b0;
        endcase
        dec_be = '1;
        if (dec_st) dec_be = BE_W'((1 << dec_bytes) - 1) << off;
`ifdef LSU_UNALIGNED_EN
        if (dec_op == MEM_LWL || dec_op == MEM_LWR) begin
            dec_mis = 1'b0;
            dec_be  = BE_W'((dec_op == MEM_LWL) ? 4'((5'd1 << (3'(off[1:0]) + 3'd1)) - 5'd1)
                                                 : 4'(4'hF << off[1:0]))
                      << (off - OFF_W'(off[1:0]));
        end
`endif
        for (int i = 0; i < BE_W; i++) begin
            case (dec_bytes)
                1:       dec_wdata[8*i +: 8] = req_wdata[7:0];
                2:       dec_wdata[8*i +: 8] = req_wdata[8*(i%2) +: 8];
                4:       dec_wdata[8*i +: 8] = req_wdata[8*(i%4) +: 8];
                default: dec_wdata[8*i +: 8] = req_wdata[8*i +: 8];
            endcase
        end
    end

    assign push      = (state_q == ST_REQ) && bus_addr_ok;
    assign pop       = bus_data_ok && !fifo_empty;
    assign occ       = {1'b0, fifo_count} + (CNT_W+1)'(push);
    // Exceptions only go out when nothing is in flight so responses stay ordered.
    assign req_ready = !rst && ((state_q == ST_IDLE) || push)
                       && (occ < (CNT_W+1)'(PEND_DEPTH)) && (!dec_mis || occ == '0);
    assign accept    = req_valid && req_ready;

    lsu_pend_fifo #(.W(ENT_W), .DEPTH(PEND_DEPTH), .CNT_W(CNT_W)) u_pend (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(ent_q), .dout(fifo_dout),
        .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );

    assign h_op  = fifo_dout[ENT_W-1 -: 8];
    assign h_off = fifo_dout[ENT_W-9 -: OFF_W];
    assign sh    = bus_rdata >> {h_off, 3'b000};

    always_comb begin
`ifdef LSU_UNALIGNED_EN
        logic [31:0] word, old32;
        logic [1:0]  o;
        o     = h_off[1:0];
        word  = 32'(bus_rdata >> {h_off - OFF_W'(o), 3'b000});
        old32 = fifo_dout[31:0];
`endif
        case (h_op)
            MEM_LB:  ld_data = ext(sh, 8, sh[7]);
            MEM_LBU: ld_data = ext(sh, 8, 1'b0);
            MEM_LH:  ld_data = ext(sh, 16, sh[15]);
            MEM_LHU: ld_data = ext(sh, 16, 1'b0);
            MEM_LW:  ld_data = ext(sh, 32, sh[31]);
            MEM_LD:  ld_data = (DATA_W == 64) ? sh : '0;
`ifdef LSU_UNALIGNED_EN
            MEM_LWL: begin
                word    = (word << {2'd3 - o, 3'b000}) | (old32 & (32'hFFFF_FFFF >> {3'(o) + 3'd1, 3'b000}));
                ld_data = ext(DATA_W'(word), 32, word[31]);
            end
            MEM_LWR: begin
                word    = (word >> {o, 3'b000}) | (old32 & ~(32'hFFFF_FFFF >> {o, 3'b000}));
                ld_data = ext(DATA_W'(word), 32, word[31]);
            end
`endif
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_be_d     = bus_be_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        ent_d        = ent_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        adel_d       = 1'b0;
        ades_d       = 1'b0;
        bad_d        = '0;
        case (state_q)
            ST_REQ: if (bus_addr_ok) begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
            ST_EXC:  state_d = ST_IDLE;
            default: ;
        endcase
        if (accept) begin
            if (dec_mis) begin
                state_d      = ST_EXC;
                resp_valid_d = 1'b1;
                adel_d       = !dec_st;
                ades_d       = dec_st;
                bad_d        = req_addr;
            end else begin
                state_d     = ST_REQ;
                bus_req_d   = 1'b1;
                bus_wr_d    = dec_st;
                bus_be_d    = dec_be;
                bus_addr_d  = req_addr & ~ADDR_W'(BE_W - 1);
                bus_wdata_d = dec_wdata;
`ifdef LSU_UNALIGNED_EN
                ent_d       = {dec_op, off, req_wdata};
`else
                ent_d       = {dec_op, off};
`endif
            end
        end
        if (pop) begin
            resp_valid_d = 1'b1;
            resp_rdata_d = ld_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_be_q     <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            ent_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            adel_q       <= 1'b0;
            ades_q       <= 1'b0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_be_q     <= bus_be_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            ent_q        <= ent_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            adel_q       <= adel_d;
            ades_q       <= ades_d;
            bad_q        <= bad_d;
        end
    end

    assign bus_req       = bus_req_q;
    assign bus_wr        = bus_wr_q;
    assign bus_be        = bus_be_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_exc_adel = adel_q;
    assign resp_exc_ades = ades_q;
    assign resp_badvaddr = bad_q;

endmodule

// File: tb/tb_lsu_access_unit.sv
// Scoreboard bench for lsu_access_unit: vector table plus back-pressure and reset sequences.
module tb_lsu_access_unit;
    import lsu_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic        bus_req, bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic        resp_valid, resp_exc_adel, resp_exc_ades;
    logic [31:0] resp_rdata, resp_badvaddr;

    always #5 clk = ~clk;

    lsu_access_unit #(.DATA_W(32), .ADDR_W(32), .PEND_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_exc_adel(resp_exc_adel), .resp_exc_ades(resp_exc_ades),
        .resp_badvaddr(resp_badvaddr)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr, wdata, rdata;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] bwdata, rres;
        logic        adel, ades;
    } vec_t;
    typedef struct { logic wr; logic [3:0] be; logic [31:0] addr, wdata, rdata; } bus_t;
    typedef struct { logic [31:0] rdata, bad; logic adel, ades; } rsp_t;

    bus_t        bus_q[$];
    rsp_t        sb_q[$];
    logic [31:0] beat_rd[$];
    int          beat_due[$];
    int          checks = 0, failures = 0, cyc = 0, resp_cnt = 0;
    int          addr_delay = 0, data_delay = 1;
    vec_t        tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Bus slave: grants after addr_delay cycles, answers data_delay cycles later, in order.
    initial begin
        bit          inflight = 0;
        int          wait_n = 0;
        bus_t        cur;
        logic [31:0] snap_a;
        logic [36:0] snap_d;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            if (beat_due.size() > 0 && beat_due[0] <= cyc) begin
                bus_data_ok = 1'b1;
                bus_rdata   = beat_rd.pop_front();
                void'(beat_due.pop_front());
            end
            if (rst) begin
                inflight = 0;
                wait_n   = 0;
            end else if (bus_req) begin
                if (!inflight) begin
                    chk("bus_req_expected", 64'(bus_q.size() != 0), 1);
                    if (bus_q.size() == 0) begin
                        bus_addr_ok = 1'b1;
                        continue;
                    end
                    cur = bus_q.pop_front();
                    inflight = 1;
                    wait_n   = 0;
                    chk("bus_wr", bus_wr, cur.wr);
                    chk("bus_be", bus_be, cur.be);
                    chk("bus_addr", bus_addr, cur.addr);
                    if (cur.wr) chk("bus_wdata", bus_wdata, cur.wdata);
                    snap_a = bus_addr;
                    snap_d = {bus_wr, bus_be, bus_wdata};
                end else begin
                    chk("bus_addr_stable", bus_addr, snap_a);
                    chk("bus_ctl_stable", {bus_wr, bus_be, bus_wdata}, snap_d);
                end
                if (wait_n >= addr_delay) begin
                    bus_addr_ok = 1'b1;
                    inflight    = 0;
                    beat_due.push_back(cyc + data_delay);
                    beat_rd.push_back(cur.rdata);
                end else begin
                    wait_n++;
                end
            end else if (inflight) begin
                chk("bus_req_held", bus_req, 1);
                inflight = 0;
            end
        end
    end

    // Response monitor: every pulse must match the oldest expected completion.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cnt++;
                chk("resp_expected", 64'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_adel", resp_exc_adel, e.adel);
                    chk("resp_ades", resp_exc_ades, e.ades);
                    chk("resp_badvaddr", resp_badvaddr, e.bad);
                end
            end
        end
    end

    task automatic issue(input vec_t v);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        #1;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("accept_in_time", 64'(n < 200), 1);
        if (!(v.adel || v.ades))
            bus_q.push_back('{wr: v.wr, be: v.be, addr: v.addr & ~32'h3, wdata: v.bwdata, rdata: v.rdata});
        sb_q.push_back('{rdata: v.rres, bad: (v.adel || v.ades) ? v.addr : 32'h0,
                         adel: v.adel, ades: v.ades});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_bus_req"}, bus_req, 0);
        chk({tag, "_bus_wr"}, bus_wr, 0);
        chk({tag, "_bus_be"}, bus_be, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_exc"}, {resp_exc_adel, resp_exc_ades}, 0);
        chk({tag, "_badvaddr"}, resp_badvaddr, 0);
    endtask

    initial begin
        vec_t v;
        int   n;
        #200000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        //            op       addr          wdata         rdata         wr    be       bwdata        rres          adel  ades
        tbl[0]  = '{MEM_LB,  32'h0000_1003, 32'h0,        32'h80FF_FF00, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0};
        tbl[1]  = '{MEM_SH,  32'h0000_2002, 32'h0000_1234, 32'h0,       1'b1, 4'b1100, 32'h1234_1234, 32'h0,       1'b0, 1'b0};
        tbl[2]  = '{MEM_LW,  32'h0000_3001, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0};
        tbl[3]  = '{MEM_SW,  32'h0000_3002, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,         1'b0, 1'b1};
        tbl[4]  = '{MEM_LBU, 32'h0000_1001, 32'h0,        32'h1122_8344, 1'b0, 4'b1111, 32'h0,        32'h0000_0083, 1'b0, 1'b0};
        tbl[5]  = '{MEM_LH,  32'h0000_1002, 32'h0,        32'h8001_0000, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0};
        tbl[6]  = '{MEM_LHU, 32'h0000_1000, 32'h0,        32'h1234_F00D, 1'b0, 4'b1111, 32'h0,        32'h0000_F00D, 1'b0, 1'b0};
        tbl[7]  = '{MEM_LW,  32'h0000_1004, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0};
        tbl[8]  = '{MEM_SB,  32'h0000_4001, 32'h0000_00AB, 32'h0,       1'b1, 4'b0010, 32'hABAB_ABAB, 32'h0,       1'b0, 1'b0};
        tbl[9]  = '{MEM_SW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,       1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,       1'b0, 1'b0};
        tbl[10] = '{MEM_LH,  32'h0000_1001, 32'h0,        32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,         1'b1, 1'b0};
        tbl[11] = '{MEM_SB,  32'h0000_4003, 32'h0000_005A, 32'h0,       1'b1, 4'b1000, 32'h5A5A_5A5A, 32'h0,       1'b0, 1'b0};
        tbl[12] = '{MEM_LD,  32'h0000_5000, 32'h0,        32'hFFFF_FFFF, 1'b0, 4'b1111, 32'h0,        32'h0,         1'b0, 1'b0};
        tbl[13] = '{MEM_SH,  32'h0000_2001, 32'h0000_BEEF, 32'h0,       1'b1, 4'b0000, 32'h0,        32'h0,         1'b0, 1'b1};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            addr_delay = i % 3;
            data_delay = 1 + (i % 2);
            issue(tbl[i]);
        end
        drain();

        // Pending FIFO full: third back-to-back load must be held off.
        addr_delay = 0;
        data_delay = 5;
        issue('{MEM_LW, 32'h6000, 32'h0, 32'h1111_1111, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b0, 1'b0});
        issue('{MEM_LW, 32'h6004, 32'h0, 32'h2222_2222, 1'b0, 4'hF, 32'h0, 32'h2222_2222, 1'b0, 1'b0});
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = MEM_LW;
        req_addr  = 32'h6008;
        #1;
        chk("third_held_off", req_ready, 0);
        issue('{MEM_LW, 32'h6008, 32'h0, 32'h3333_3333, 1'b0, 4'hF, 32'h0, 32'h3333_3333, 1'b0, 1'b0});
        drain();

        // Address phase stalled: bus outputs must hold until granted.
        addr_delay = 4;
        data_delay = 1;
        issue('{MEM_SW, 32'h7008, 32'h89AB_CDEF, 32'h0, 1'b1, 4'hF, 32'h89AB_CDEF, 32'h0, 1'b0, 1'b0});
        drain();

        // Reset with two loads outstanding; their late data must be ignored.
        addr_delay = 0;
        data_delay = 30;
        issue('{MEM_LW, 32'h8000, 32'h0, 32'hAAAA_AAAA, 1'b0, 4'hF, 32'h0, 32'hAAAA_AAAA, 1'b0, 1'b0});
        issue('{MEM_LW, 32'h8004, 32'h0, 32'hBBBB_BBBB, 1'b0, 4'hF, 32'h0, 32'hBBBB_BBBB, 1'b0, 1'b0});
        n = 0;
        while (beat_due.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("two_pending", beat_due.size(), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle_outputs("midrst");
        sb_q.delete();
        resp_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (beat_due.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("stray_data_beats_seen", beat_due.size(), 0);
        chk("no_resp_after_reset", resp_cnt, 0);

        data_delay = 1;
        issue(tbl[0]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
